// File: rtl/npc_axi_pkg.sv
// Shared AXI-Lite definitions: response codes, crossbar FSM encodings and the
// default SRAM/UART address windows.
package npc_axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [31:0] DEF_MEM_BASE  = 32'h8000_0000;
   localparam logic [31:0] DEF_MEM_SIZE  = 32'h0800_0000;
   localparam logic [31:0] DEF_UART_BASE = 32'ha000_03f8;
   localparam logic [31:0] DEF_UART_SIZE = 32'h0000_0008;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_DATA = 2'd1,
      RD_ERR  = 2'd2
   } rd_state_e;

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_REQ  = 2'd1,
      WR_RESP = 2'd2,
      WR_ERR  = 2'd3
   } wr_state_e;

   // Subtracting first keeps the window check correct for windows touching 2^32.
   function automatic logic in_window(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] size);
      logic [31:0] offs;
      offs = addr - base;
      return (addr >= base) && (offs < size);
   endfunction

endpackage

// File: rtl/axi_addr_decode.sv
// Address decoder for the 1-to-2 crossbar: slave 0 = SRAM, slave 1 = UART,
// anything else is a miss. UART takes priority if the windows overlap.
module axi_addr_decode
   import npc_axi_pkg::*;
#(
   parameter logic [31:0] MEM_BASE  = DEF_MEM_BASE,
   parameter logic [31:0] MEM_SIZE  = DEF_MEM_SIZE,
   parameter logic [31:0] UART_BASE = DEF_UART_BASE,
   parameter logic [31:0] UART_SIZE = DEF_UART_SIZE
) (
   input  logic [31:0] i_addr,
   output logic        o_hit0,
   output logic        o_hit1,
   output logic        o_miss
);

   logic w_in_mem;
   logic w_in_uart;

   assign w_in_mem  = in_window(i_addr, MEM_BASE, MEM_SIZE);
   assign w_in_uart = in_window(i_addr, UART_BASE, UART_SIZE);

   assign o_hit1 = w_in_uart;
   assign o_hit0 = w_in_mem & ~w_in_uart;
   assign o_miss = ~w_in_mem & ~w_in_uart;

endmodule

// File: rtl/axi_lite_xbar_1to2.sv
// AXI4-Lite 1-master-to-2-slave crossbar (SRAM, UART) with local DECERR for
// unmapped addresses. Independent read/write paths, one outstanding each.
module axi_lite_xbar_1to2
   import npc_axi_pkg::*;
#(
   parameter logic [31:0] MEM_BASE  = DEF_MEM_BASE,
   parameter logic [31:0] MEM_SIZE  = DEF_MEM_SIZE,
   parameter logic [31:0] UART_BASE = DEF_UART_BASE,
   parameter logic [31:0] UART_SIZE = DEF_UART_SIZE
) (
   input  logic        clk,
   input  logic        rst,
   // upstream master port
   input  logic [31:0] s_araddr,
   input  logic        s_arvalid,
   output logic        s_arready,
   output logic [31:0] s_rdata,
   output logic [1:0]  s_rresp,
   output logic        s_rvalid,
   input  logic        s_rready,
   input  logic [31:0] s_awaddr,
   input  logic        s_awvalid,
   output logic        s_awready,
   input  logic [31:0] s_wdata,
   input  logic [3:0]  s_wstrb,
   input  logic        s_wvalid,
   output logic        s_wready,
   output logic [1:0]  s_bresp,
   output logic        s_bvalid,
   input  logic        s_bready,
   // slave 0 (SRAM)
   output logic [31:0] m0_araddr,
   output logic        m0_arvalid,
   input  logic        m0_arready,
   input  logic [31:0] m0_rdata,
   input  logic [1:0]  m0_rresp,
   input  logic        m0_rvalid,
   output logic        m0_rready,
   output logic [31:0] m0_awaddr,
   output logic        m0_awvalid,
   input  logic        m0_awready,
   output logic [31:0] m0_wdata,
   output logic [3:0]  m0_wstrb,
   output logic        m0_wvalid,
   input  logic        m0_wready,
   input  logic [1:0]  m0_bresp,
   input  logic        m0_bvalid,
   output logic        m0_bready,
   // slave 1 (UART)
   output logic [31:0] m1_araddr,
   output logic        m1_arvalid,
   input  logic        m1_arready,
   input  logic [31:0] m1_rdata,
   input  logic [1:0]  m1_rresp,
   input  logic        m1_rvalid,
   output logic        m1_rready,
   output logic [31:0] m1_awaddr,
   output logic        m1_awvalid,
   input  logic        m1_awready,
   output logic [31:0] m1_wdata,
   output logic [3:0]  m1_wstrb,
   output logic        m1_wvalid,
   input  logic        m1_wready,
   input  logic [1:0]  m1_bresp,
   input  logic        m1_bvalid,
   output logic        m1_bready,
   // FSM observation
   output rd_state_e   o_rd_state,
   output wr_state_e   o_wr_state
);

   // Handshake rule on every channel: a beat transfers on the rising clk edge
   // where valid && ready are both high; valid never waits on ready.

   rd_state_e   r_rd_state, w_rd_next;
   wr_state_e   r_wr_state, w_wr_next;
   logic        r_rsel;
   logic        r_wsel, w_wsel_next;
   logic        r_aw_done, w_aw_done_next;
   logic        r_w_done, w_w_done_next;
   logic        w_aw_now, w_w_now;

   logic        w_ar_hit0, w_ar_hit1, w_ar_miss;
   logic        w_aw_hit0, w_aw_hit1, w_aw_miss;
   logic        w_ar_sel, w_aw_sel;

   logic [1:0]  w_m_arvalid, w_m_rready, w_m_awvalid, w_m_wvalid, w_m_bready;
   logic [1:0]  w_m_arready, w_m_rvalid, w_m_awready, w_m_wready, w_m_bvalid;
   logic [31:0] w_m_rdata [2];
   logic [1:0]  w_m_rresp [2];
   logic [1:0]  w_m_bresp [2];

   axi_addr_decode #(
      .MEM_BASE(MEM_BASE), .MEM_SIZE(MEM_SIZE),
      .UART_BASE(UART_BASE), .UART_SIZE(UART_SIZE)
   ) u_ar_decode (
      .i_addr(s_araddr), .o_hit0(w_ar_hit0), .o_hit1(w_ar_hit1), .o_miss(w_ar_miss)
   );

   axi_addr_decode #(
      .MEM_BASE(MEM_BASE), .MEM_SIZE(MEM_SIZE),
      .UART_BASE(UART_BASE), .UART_SIZE(UART_SIZE)
   ) u_aw_decode (
      .i_addr(s_awaddr), .o_hit0(w_aw_hit0), .o_hit1(w_aw_hit1), .o_miss(w_aw_miss)
   );

   // A non-miss address is slave 1 exactly when it hits the UART window.
   assign w_ar_sel = w_ar_hit1 & ~w_ar_hit0;
   assign w_aw_sel = w_aw_hit1 & ~w_aw_hit0;

   assign w_m_arready = {m1_arready, m0_arready};
   assign w_m_rvalid  = {m1_rvalid, m0_rvalid};
   assign w_m_awready = {m1_awready, m0_awready};
   assign w_m_wready  = {m1_wready, m0_wready};
   assign w_m_bvalid  = {m1_bvalid, m0_bvalid};
   assign w_m_rdata[0] = m0_rdata;
   assign w_m_rdata[1] = m1_rdata;
   assign w_m_rresp[0] = m0_rresp;
   assign w_m_rresp[1] = m1_rresp;
   assign w_m_bresp[0] = m0_bresp;
   assign w_m_bresp[1] = m1_bresp;

   assign m0_araddr = s_araddr;
   assign m1_araddr = s_araddr;
   assign m0_awaddr = s_awaddr;
   assign m1_awaddr = s_awaddr;
   assign m0_wdata  = s_wdata;
   assign m1_wdata  = s_wdata;
   assign m0_wstrb  = s_wstrb;
   assign m1_wstrb  = s_wstrb;

   assign m0_arvalid = w_m_arvalid[0];
   assign m1_arvalid = w_m_arvalid[1];
   assign m0_rready  = w_m_rready[0];
   assign m1_rready  = w_m_rready[1];
   assign m0_awvalid = w_m_awvalid[0];
   assign m1_awvalid = w_m_awvalid[1];
   assign m0_wvalid  = w_m_wvalid[0];
   assign m1_wvalid  = w_m_wvalid[1];
   assign m0_bready  = w_m_bready[0];
   assign m1_bready  = w_m_bready[1];

   assign o_rd_state = r_rd_state;
   assign o_wr_state = r_wr_state;

   // ---------------- read path ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_state <= RD_IDLE;
         r_rsel     <= 1'b0;
      end else begin
         r_rd_state <= w_rd_next;
         if (r_rd_state == RD_IDLE && w_rd_next == RD_DATA)
            r_rsel <= w_ar_sel;
      end
   end

   always_comb begin
      w_rd_next   = r_rd_state;
      w_m_arvalid = 2'b00;
      w_m_rready  = 2'b00;
      s_arready   = 1'b0;
      s_rvalid    = 1'b0;
      s_rresp     = RESP_OKAY;
      s_rdata     = 32'h0;
      case (r_rd_state)
         RD_IDLE: begin
            if (w_ar_miss) begin
               s_arready = 1'b1;
               if (s_arvalid) w_rd_next = RD_ERR;
            end else begin
               w_m_arvalid[w_ar_sel] = s_arvalid;
               s_arready             = w_m_arready[w_ar_sel];
               if (s_arvalid && w_m_arready[w_ar_sel]) w_rd_next = RD_DATA;
            end
         end
         RD_DATA: begin
            s_rvalid           = w_m_rvalid[r_rsel];
            s_rresp            = w_m_rresp[r_rsel];
            s_rdata            = w_m_rdata[r_rsel];
            w_m_rready[r_rsel] = s_rready;
            if (w_m_rvalid[r_rsel] && s_rready) w_rd_next = RD_IDLE;
         end
         RD_ERR: begin
            s_rvalid = 1'b1;
            s_rresp  = RESP_DECERR;
            if (s_rready) w_rd_next = RD_IDLE;
         end
         default: w_rd_next = RD_IDLE;
      endcase
      if (rst) begin
         s_arready   = 1'b0;
         s_rvalid    = 1'b0;
         w_m_arvalid = 2'b00;
         w_m_rready  = 2'b00;
      end
   end

   // ---------------- write path ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_state <= WR_IDLE;
         r_wsel     <= 1'b0;
         r_aw_done  <= 1'b0;
         r_w_done   <= 1'b0;
      end else begin
         r_wr_state <= w_wr_next;
         r_wsel     <= w_wsel_next;
         r_aw_done  <= w_aw_done_next;
         r_w_done   <= w_w_done_next;
      end
   end

   always_comb begin
      w_wr_next      = r_wr_state;
      w_wsel_next    = r_wsel;
      w_aw_done_next = r_aw_done;
      w_w_done_next  = r_w_done;
      w_aw_now       = 1'b0;
      w_w_now        = 1'b0;
      w_m_awvalid    = 2'b00;
      w_m_wvalid     = 2'b00;
      w_m_bready     = 2'b00;
      s_awready      = 1'b0;
      s_wready       = 1'b0;
      s_bvalid       = 1'b0;
      s_bresp        = RESP_OKAY;
      case (r_wr_state)
         WR_IDLE: begin
            if (s_awvalid && s_wvalid) begin
               if (w_aw_miss) begin
                  s_awready = 1'b1;
                  s_wready  = 1'b1;
                  w_wr_next = WR_ERR;
               end else begin
                  // Present to the slave immediately so a ready slave costs no cycle.
                  w_wsel_next           = w_aw_sel;
                  w_m_awvalid[w_aw_sel] = 1'b1;
                  w_m_wvalid[w_aw_sel]  = 1'b1;
                  s_awready             = w_m_awready[w_aw_sel];
                  s_wready              = w_m_wready[w_aw_sel];
                  w_aw_now              = w_m_awready[w_aw_sel];
                  w_w_now               = w_m_wready[w_aw_sel];
                  if (w_aw_now && w_w_now) begin
                     w_wr_next = WR_RESP;
                  end else begin
                     w_wr_next      = WR_REQ;
                     w_aw_done_next = w_aw_now;
                     w_w_done_next  = w_w_now;
                  end
               end
            end
         end
         WR_REQ: begin
            w_m_awvalid[r_wsel] = s_awvalid & ~r_aw_done;
            w_m_wvalid[r_wsel]  = s_wvalid & ~r_w_done;
            s_awready           = w_m_awready[r_wsel] & ~r_aw_done;
            s_wready            = w_m_wready[r_wsel] & ~r_w_done;
            w_aw_now            = r_aw_done | (s_awvalid & w_m_awready[r_wsel]);
            w_w_now             = r_w_done | (s_wvalid & w_m_wready[r_wsel]);
            if (w_aw_now && w_w_now) begin
               w_wr_next      = WR_RESP;
               w_aw_done_next = 1'b0;
               w_w_done_next  = 1'b0;
            end else begin
               w_aw_done_next = w_aw_now;
               w_w_done_next  = w_w_now;
            end
         end
         WR_RESP: begin
            s_bvalid           = w_m_bvalid[r_wsel];
            s_bresp            = w_m_bresp[r_wsel];
            w_m_bready[r_wsel] = s_bready;
            if (w_m_bvalid[r_wsel] && s_bready) w_wr_next = WR_IDLE;
         end
         WR_ERR: begin
            s_bvalid = 1'b1;
            s_bresp  = RESP_DECERR;
            if (s_bready) w_wr_next = WR_IDLE;
         end
         default: w_wr_next = WR_IDLE;
      endcase
      if (rst) begin
         s_awready   = 1'b0;
         s_wready    = 1'b0;
         s_bvalid    = 1'b0;
         w_m_awvalid = 2'b00;
         w_m_wvalid  = 2'b00;
         w_m_bready  = 2'b00;
      end
   end

endmodule

// File: tb/tb_axi_lite_xbar_1to2.sv
// Directed bench for axi_lite_xbar_1to2: routing, DECERR, split AW/W,
// concurrent read/write and mid-transaction reset.
module tb_axi_lite_xbar_1to2;
   import npc_axi_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] s_araddr, s_awaddr, s_wdata, s_rdata;
   logic        s_arvalid, s_arready, s_rvalid, s_rready;
   logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic [3:0]  s_wstrb;
   logic [1:0]  s_rresp, s_bresp;
   logic [31:0] m0_araddr, m0_rdata, m0_awaddr, m0_wdata;
   logic [31:0] m1_araddr, m1_rdata, m1_awaddr, m1_wdata;
   logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_awvalid, m0_awready;
   logic        m0_wvalid, m0_wready, m0_bvalid, m0_bready;
   logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_awvalid, m1_awready;
   logic        m1_wvalid, m1_wready, m1_bvalid, m1_bready;
   logic [1:0]  m0_rresp, m0_bresp, m1_rresp, m1_bresp;
   logic [3:0]  m0_wstrb, m1_wstrb;
   rd_state_e   o_rd_state;
   wr_state_e   o_wr_state;

   int n_checks = 0;
   int n_fail   = 0;

   // handshake / activity monitors
   int m0_aw_cnt = 0, m0_w_cnt = 0, m1_aw_cnt = 0, m1_w_cnt = 0;
   int s_b_cnt = 0, s_r_cnt = 0, m0_act = 0, m1_act = 0;
   int snap_a, snap_b, snap_c, snap_d;
   int dly;

   logic [31:0] dec_addr [6];
   logic [2:0]  dec_exp  [6];

   axi_lite_xbar_1to2 dut (
      .clk(clk), .rst(rst),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
      .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
      .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
      .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
      .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
      .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
      .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
      .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
      .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
      .o_rd_state(o_rd_state), .o_wr_state(o_wr_state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (m0_awvalid && m0_awready) m0_aw_cnt++;
      if (m0_wvalid && m0_wready)   m0_w_cnt++;
      if (m1_awvalid && m1_awready) m1_aw_cnt++;
      if (m1_wvalid && m1_wready)   m1_w_cnt++;
      if (s_bvalid && s_bready)     s_b_cnt++;
      if (s_rvalid && s_rready)     s_r_cnt++;
      if (m0_arvalid || m0_awvalid || m0_wvalid || m0_rready || m0_bready) m0_act++;
      if (m1_arvalid || m1_awvalid || m1_wvalid || m1_rready || m1_bready) m1_act++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      s_araddr = '0; s_arvalid = 0; s_rready = 0;
      s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0; s_bready = 0;
      m0_arready = 0; m0_rdata = '0; m0_rresp = '0; m0_rvalid = 0;
      m0_awready = 0; m0_wready = 0; m0_bresp = '0; m0_bvalid = 0;
      m1_arready = 0; m1_rdata = '0; m1_rresp = '0; m1_rvalid = 0;
      m1_awready = 0; m1_wready = 0; m1_bresp = '0; m1_bvalid = 0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      // during reset: address 0 is a miss, yet arready must be held low
      chk("rst_arready", {31'b0, s_arready}, 32'h0);
      chk("rst_rvalid",  {31'b0, s_rvalid},  32'h0);
      chk("rst_bvalid",  {31'b0, s_bvalid},  32'h0);
      rst = 1'b0;
      tick();
      chk("post_rst_rd_state", 32'(o_rd_state), 32'(RD_IDLE));
      chk("post_rst_wr_state", 32'(o_wr_state), 32'(WR_IDLE));
      chk("post_rst_rvalid",   {31'b0, s_rvalid}, 32'h0);
      chk("post_rst_awready",  {31'b0, s_awready}, 32'h0);

      // decode boundaries: {m0_arvalid, m1_arvalid, s_arready} with both slaves not ready
      dec_addr[0] = 32'h8000_0000; dec_exp[0] = 3'b100;
      dec_addr[1] = 32'h87ff_fffc; dec_exp[1] = 3'b100;
      dec_addr[2] = 32'h8800_0000; dec_exp[2] = 3'b001;
      dec_addr[3] = 32'ha000_03f8; dec_exp[3] = 3'b010;
      dec_addr[4] = 32'ha000_03ff; dec_exp[4] = 3'b010;
      dec_addr[5] = 32'ha000_0400; dec_exp[5] = 3'b001;
      for (int i = 0; i < 6; i++) begin
         s_araddr = dec_addr[i]; s_arvalid = 1;
         #1;
         chk($sformatf("decode_%h", dec_addr[i]), {29'b0, m0_arvalid, m1_arvalid, s_arready},
             {29'b0, dec_exp[i]});
         s_arvalid = 0;
         #1;
      end

      // 1: SRAM read, data after 3 cycles
      snap_a = m1_act;
      s_araddr = 32'h8000_0010; s_arvalid = 1; s_rready = 1; m0_arready = 1;
      #1;
      chk("t1_m0_arvalid", {31'b0, m0_arvalid}, 32'h1);
      chk("t1_s_arready",  {31'b0, s_arready},  32'h1);
      chk("t1_m0_araddr",  m0_araddr, 32'h8000_0010);
      tick();
      s_arvalid = 0; m0_arready = 0;
      #1;
      chk("t1_state_data", 32'(o_rd_state), 32'(RD_DATA));
      chk("t1_arready_busy", {31'b0, s_arready}, 32'h0);
      chk("t1_rvalid_wait",  {31'b0, s_rvalid},  32'h0);
      tick();
      tick();
      m0_rvalid = 1; m0_rdata = 32'h1234_5678; m0_rresp = RESP_OKAY;
      #1;
      chk("t1_rvalid", {31'b0, s_rvalid}, 32'h1);
      chk("t1_rdata",  s_rdata, 32'h1234_5678);
      chk("t1_rresp",  {30'b0, s_rresp}, 32'h0);
      chk("t1_m0_rready", {31'b0, m0_rready}, 32'h1);
      tick();
      m0_rvalid = 0; m0_rdata = '0;
      #1;
      chk("t1_state_idle", 32'(o_rd_state), 32'(RD_IDLE));
      chk("t1_m1_quiet", 32'(m1_act - snap_a), 32'h0);
      idle_inputs();

      // 2: UART write with random slave delay
      snap_a = m1_aw_cnt; snap_b = m1_w_cnt; snap_c = m0_act; snap_d = s_b_cnt;
      dly = $urandom_range(0, 15);
      s_awaddr = 32'ha000_03f8; s_awvalid = 1; s_wdata = 32'h41; s_wstrb = 4'hf; s_wvalid = 1;
      s_bready = 1;
      #1;
      chk("t2_m1_awvalid", {31'b0, m1_awvalid}, 32'h1);
      chk("t2_m1_wdata",   m1_wdata, 32'h41);
      chk("t2_m0_awvalid", {31'b0, m0_awvalid}, 32'h0);
      repeat (dly) tick();
      m1_awready = 1; m1_wready = 1;
      #1;
      chk("t2_s_awready", {31'b0, s_awready}, 32'h1);
      tick();
      s_awvalid = 0; s_wvalid = 0; m1_awready = 0; m1_wready = 0;
      #1;
      chk("t2_state_resp", 32'(o_wr_state), 32'(WR_RESP));
      m1_bvalid = 1; m1_bresp = RESP_OKAY;
      #1;
      chk("t2_bvalid", {31'b0, s_bvalid}, 32'h1);
      chk("t2_bresp",  {30'b0, s_bresp},  32'h0);
      tick();
      m1_bvalid = 0;
      #1;
      chk("t2_state_idle", 32'(o_wr_state), 32'(WR_IDLE));
      chk("t2_aw_count", 32'(m1_aw_cnt - snap_a), 32'h1);
      chk("t2_w_count",  32'(m1_w_cnt - snap_b),  32'h1);
      chk("t2_b_count",  32'(s_b_cnt - snap_d),   32'h1);
      chk("t2_m0_quiet", 32'(m0_act - snap_c),    32'h0);
      idle_inputs();

      // 3: unmapped read -> local DECERR
      snap_a = m0_act + m1_act;
      s_araddr = 32'h0000_1000; s_arvalid = 1; s_rready = 1;
      #1;
      chk("t3_arready", {31'b0, s_arready}, 32'h1);
      tick();
      s_arvalid = 0;
      #1;
      chk("t3_rvalid", {31'b0, s_rvalid}, 32'h1);
      chk("t3_rresp",  {30'b0, s_rresp},  32'h3);
      chk("t3_rdata",  s_rdata, 32'h0);
      tick();
      chk("t3_state_idle", 32'(o_rd_state), 32'(RD_IDLE));
      chk("t3_no_downstream", 32'(m0_act + m1_act - snap_a), 32'h0);

      // unmapped write -> local DECERR
      s_awaddr = 32'h9000_0000; s_awvalid = 1; s_wvalid = 1; s_wdata = 32'h77; s_bready = 0;
      #1;
      chk("t3w_awready", {31'b0, s_awready}, 32'h1);
      chk("t3w_wready",  {31'b0, s_wready},  32'h1);
      tick();
      s_awvalid = 0; s_wvalid = 0;
      #1;
      chk("t3w_bvalid", {31'b0, s_bvalid}, 32'h1);
      chk("t3w_bresp",  {30'b0, s_bresp},  32'h3);
      tick();
      chk("t3w_bvalid_held", {31'b0, s_bvalid}, 32'h1);
      s_bready = 1;
      tick();
      chk("t3w_state_idle", 32'(o_wr_state), 32'(WR_IDLE));
      idle_inputs();

      // 4: SRAM accepts AW two cycles before W; master keeps awvalid up
      snap_a = m0_aw_cnt; snap_b = m0_w_cnt; snap_c = s_b_cnt;
      s_awaddr = 32'h8000_0100; s_awvalid = 1; s_wdata = 32'hdead_0004; s_wstrb = 4'h3;
      s_wvalid = 1; s_bready = 1; m0_awready = 1;
      #1;
      chk("t4_awready", {31'b0, s_awready}, 32'h1);
      chk("t4_wready0", {31'b0, s_wready},  32'h0);
      tick();
      chk("t4_state_req",  32'(o_wr_state), 32'(WR_REQ));
      chk("t4_awvalid_off", {31'b0, m0_awvalid}, 32'h0);
      chk("t4_wvalid_on",   {31'b0, m0_wvalid},  32'h1);
      tick();
      chk("t4_wvalid_hold", {31'b0, m0_wvalid}, 32'h1);
      chk("t4_wstrb", {28'b0, m0_wstrb}, 32'h3);
      m0_wready = 1;
      #1;
      chk("t4_wready1", {31'b0, s_wready}, 32'h1);
      tick();
      s_awvalid = 0; s_wvalid = 0; m0_awready = 0; m0_wready = 0;
      #1;
      chk("t4_state_resp", 32'(o_wr_state), 32'(WR_RESP));
      m0_bvalid = 1; m0_bresp = RESP_OKAY;
      tick();
      m0_bvalid = 0;
      tick();
      chk("t4_aw_count", 32'(m0_aw_cnt - snap_a), 32'h1);
      chk("t4_w_count",  32'(m0_w_cnt - snap_b),  32'h1);
      chk("t4_b_count",  32'(s_b_cnt - snap_c),   32'h1);
      idle_inputs();

      // 5: concurrent SRAM read and UART write; decoy responses on the other slaves
      s_araddr = 32'h8000_0020; s_arvalid = 1; s_rready = 1; m0_arready = 1;
      s_awaddr = 32'ha000_03fc; s_awvalid = 1; s_wvalid = 1; s_wdata = 32'h55; s_bready = 1;
      m1_awready = 1; m1_wready = 1;
      #1;
      chk("t5_m0_arvalid", {31'b0, m0_arvalid}, 32'h1);
      chk("t5_m1_awvalid", {31'b0, m1_awvalid}, 32'h1);
      chk("t5_m1_arvalid", {31'b0, m1_arvalid}, 32'h0);
      chk("t5_m0_awvalid", {31'b0, m0_awvalid}, 32'h0);
      tick();
      idle_inputs();
      s_rready = 1; s_bready = 1;
      m0_rvalid = 1; m0_rdata = 32'hcafe_0001; m0_rresp = RESP_OKAY;
      m1_rvalid = 1; m1_rdata = 32'hdead_beef; m1_rresp = 2'b10;
      m1_bvalid = 1; m1_bresp = RESP_OKAY;
      m0_bvalid = 1; m0_bresp = 2'b10;
      #1;
      chk("t5_rdata", s_rdata, 32'hcafe_0001);
      chk("t5_rresp", {30'b0, s_rresp}, 32'h0);
      chk("t5_bvalid", {31'b0, s_bvalid}, 32'h1);
      chk("t5_bresp", {30'b0, s_bresp}, 32'h0);
      chk("t5_m1_rready", {31'b0, m1_rready}, 32'h0);
      chk("t5_m0_bready", {31'b0, m0_bready}, 32'h0);
      tick();
      idle_inputs();
      #1;
      chk("t5_states", {28'b0, 2'(o_rd_state), 2'(o_wr_state)}, {28'b0, 2'(RD_IDLE), 2'(WR_IDLE)});

      // 6: reset while waiting for read data
      s_araddr = 32'h8000_0030; s_arvalid = 1; s_rready = 1; m0_arready = 1;
      tick();
      s_arvalid = 0; m0_arready = 0;
      #1;
      chk("t6_state_data", 32'(o_rd_state), 32'(RD_DATA));
      rst = 1; m0_rvalid = 1; m0_rdata = 32'h1111_2222;
      #1;
      chk("t6_rst_rvalid", {31'b0, s_rvalid}, 32'h0);
      chk("t6_rst_rready", {31'b0, m0_rready}, 32'h0);
      tick();
      rst = 0; m0_rvalid = 0;
      #1;
      chk("t6_state_idle", 32'(o_rd_state), 32'(RD_IDLE));
      chk("t6_rvalid_after", {31'b0, s_rvalid}, 32'h0);
      chk("t6_m0_rready_after", {31'b0, m0_rready}, 32'h0);
      snap_a = s_r_cnt;
      s_araddr = 32'h8000_0040; s_arvalid = 1; m0_arready = 1;
      tick();
      s_arvalid = 0; m0_arready = 0;
      m0_rvalid = 1; m0_rdata = 32'h0bad_f00d;
      #1;
      chk("t6_rdata", s_rdata, 32'h0bad_f00d);
      tick();
      m0_rvalid = 0;
      #1;
      chk("t6_r_count", 32'(s_r_cnt - snap_a), 32'h1);
      chk("t6_final_idle", 32'(o_rd_state), 32'(RD_IDLE));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
